// File: rtl/chunked_adder.sv
// chunked_adder: sequential add/subtract, CHUNK bits per cycle, carry kept between slices.
// Define ADDER_OVF_EN to add the two's-complement overflow output ovf.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CH    = (CHUNK <= 0) ? 1 : CHUNK;
  localparam int N     = WIDTH / CH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((CHUNK <= 0) || ((WIDTH % CH) != 0)) begin : g_bad_param
      $error("chunked_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [CH-1:0]      w_sa;
  logic [CH-1:0]      w_sb;
  logic [CH:0]        w_slice;
  logic               w_last;

  // operands shift right each slice, so the live slice is always the low bits
  assign w_sa    = r_a[CH-1:0];
  assign w_sb    = r_b[CH-1:0];
  assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + (CH+1)'(r_carry);
  assign w_last  = (r_idx == IDX_W'(N - 1));

`ifdef ADDER_OVF_EN
  logic r_ovf;
  logic w_msb_cin;

  // the carry into a full-adder bit is recoverable from its inputs and sum
  assign w_msb_cin = w_sa[CH-1] ^ w_sb[CH-1] ^ w_slice[CH-1];
  assign ovf       = r_ovf;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef ADDER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b ^ {WIDTH{sub}};
            r_carry    <= sub;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> CH;
          r_b     <= r_b >> CH;
          r_carry <= w_slice[CH];
          r_idx   <= r_idx + IDX_W'(1);
          for (int i = 0; i < N; i++) begin
            if (r_idx == IDX_W'(i)) begin
              r_sum[i*CH +: CH] <= w_slice[CH-1:0];
            end
          end
          if (w_last) begin
            r_cout      <= w_slice[CH];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef ADDER_OVF_EN
            r_ovf       <= w_msb_cin ^ w_slice[CH];
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
